// File: rtl/icache_fill.sv
// Direct-mapped instruction cache with one-word lines.
// Fills from the memory controller on a miss and forwards the fill word.
module icache_fill #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FETCH} state_e;

    state_e            state_q, state_d;
    logic [SETS-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [31:0]       data_q [SETS];
    logic [31:0]       miss_addr_q, miss_addr_d;
    logic [15:0]       hit_cnt_q, hit_cnt_d;
    logic [15:0]       miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0]  req_idx, fill_idx;
    logic [TAG_W-1:0]  req_tag, fill_tag;
    logic              lookup_hit;
    logic              fill_done;
    logic              fill_we;
    logic              start_miss;
    logic              fwd_hit;
    logic              unused_ok;

    assign req_idx   = imemaddr[IDX_W+1:2];
    assign req_tag   = imemaddr[31:IDX_W+2];
    assign fill_idx  = miss_addr_q[IDX_W+1:2];
    assign fill_tag  = miss_addr_q[31:IDX_W+2];
    assign unused_ok = ^imemaddr[1:0];

    // A flush in the same cycle suppresses any hit, including a forward.
    assign lookup_hit = imemREN & valid_q[req_idx]
                      & (tag_q[req_idx] == req_tag) & ~flush;
    assign fill_done  = (state_q == FETCH) & ~iwait;
    assign fill_we    = fill_done & ~flush;
    assign start_miss = (state_q == IDLE) & imemREN & ~lookup_hit;
    assign fwd_hit    = fill_done & imemREN & ~flush
                      & (imemaddr[31:2] == miss_addr_q[31:2]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_addr_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            miss_addr_q <= miss_addr_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_miss) state_d = FETCH;
            FETCH:   if (fill_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ihit     = 1'b0;
        imemload = '0;
        iREN     = 1'b0;
        iaddr    = '0;
        unique case (state_q)
            IDLE: begin
                ihit     = lookup_hit;
                imemload = lookup_hit ? data_q[req_idx] : '0;
            end
            FETCH: begin
                iREN     = 1'b1;
                iaddr    = miss_addr_q;
                ihit     = fwd_hit;
                imemload = fwd_hit ? iload : '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        valid_d     = valid_q;
        miss_addr_d = miss_addr_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        if (fill_we)
            valid_d[fill_idx] = 1'b1;
        if (flush)
            valid_d = '0;
        if (start_miss)
            miss_addr_d = {imemaddr[31:2], 2'b00};
        if (ihit && hit_cnt_q != 16'hFFFF)
            hit_cnt_d = hit_cnt_q + 16'd1;
        if (start_miss && miss_cnt_q != 16'hFFFF)
            miss_cnt_d = miss_cnt_q + 16'd1;
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_icache_fill.sv
// Scoreboard bench for icache_fill: directed fills, hits, flushes, reset.
// Expected hits are queued with their cycle stamp and checked by a monitor.
module tb_icache_fill;
    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_n    = 0;

    icache_fill #(.SETS(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .flush      (flush),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every DUT hit must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (ihit === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_hit: got data 0x%08h at cycle %0d expected no hit",
                         imemload, cyc_n);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hit_cycle", cyc_n, e.cyc);
                chk("hit_data", imemload, e.data);
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_hit(input logic [31:0] d);
        exp_t e;
        e.cyc  = cyc_n;
        e.data = d;
        sb.push_back(e);
    endtask

    // Miss on addr, hold iwait for waits cycles, then complete with data.
    task automatic fetch_fill(input logic [31:0] addr, input logic [31:0] d,
                              input int waits);
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        #1;
        chk("miss_ihit", {31'd0, ihit}, 32'd0);
        chk("idle_iren", {31'd0, iREN}, 32'd0);
        cyc();
        for (int i = 0; i < waits; i++) begin
            chk("wait_iren", {31'd0, iREN}, 32'd1);
            chk("wait_iaddr", iaddr, addr);
            chk("wait_imemload", imemload, 32'd0);
            cyc();
        end
        iwait = 1'b0;
        iload = d;
        #1;
        chk("done_iren", {31'd0, iREN}, 32'd1);
        chk("done_iaddr", iaddr, addr);
        push_hit(d);
        cyc();
        imemREN = 1'b0;
        iwait   = 1'b1;
        iload   = 32'hDEAD_BEEF;
        #1;
        chk("after_iren", {31'd0, iREN}, 32'd0);
        chk("after_iaddr", iaddr, 32'd0);
    endtask

    task automatic hit_access(input logic [31:0] addr, input logic [31:0] d);
        imemREN  = 1'b1;
        imemaddr = addr;
        push_hit(d);
        cyc();
        imemREN = 1'b0;
        #1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
    endtask

    initial begin
        RST      = 1'b1;
        imemREN  = 1'b0;
        imemaddr = '0;
        flush    = 1'b0;
        iwait    = 1'b1;
        iload    = '0;
        cyc();
        cyc();
        RST = 1'b0;
        #1;
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_iren", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_hits", {16'd0, hit_count}, 32'd0);
        chk("rst_misses", {16'd0, miss_count}, 32'd0);

        // Basic fill with forwarding, then zero-latency hit.
        fetch_fill(32'h40, 32'h8C01_0004, 3);
        hit_access(32'h40, 32'h8C01_0004);
        chk("t1_misses", {16'd0, miss_count}, 32'd1);
        chk("t1_hits", {16'd0, hit_count}, 32'd2);

        // Conflict eviction at index 0.
        fetch_fill(32'h80, 32'h1111_1111, 1);
        fetch_fill(32'h40, 32'h8C01_0004, 0);
        chk("t2_misses", {16'd0, miss_count}, 32'd3);
        chk("t2_hits", {16'd0, hit_count}, 32'd4);

        // Flush invalidates everything.
        fetch_fill(32'h44, 32'hAAAA_0044, 2);
        hit_access(32'h44, 32'hAAAA_0044);
        pulse_flush();
        fetch_fill(32'h44, 32'hBBBB_0044, 0);
        chk("t3_misses", {16'd0, miss_count}, 32'd5);
        chk("t3_hits", {16'd0, hit_count}, 32'd7);

        // Address changes mid-fill: fill still installs 0x40.
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        cyc();
        chk("t4_iaddr0", iaddr, 32'h40);
        imemaddr = 32'h48;
        cyc();
        chk("t4_iren1", {31'd0, iREN}, 32'd1);
        chk("t4_iaddr1", iaddr, 32'h40);
        iwait = 1'b0;
        iload = 32'hCCCC_0040;
        cyc();
        iwait = 1'b1;
        #1;
        chk("t4_idle_iren", {31'd0, iREN}, 32'd0);
        cyc();
        chk("t4_new_iren", {31'd0, iREN}, 32'd1);
        chk("t4_new_iaddr", iaddr, 32'h48);
        chk("t4_misses", {16'd0, miss_count}, 32'd7);
        iwait = 1'b0;
        iload = 32'hDDDD_0048;
        push_hit(32'hDDDD_0048);
        cyc();
        imemREN = 1'b0;
        iwait   = 1'b1;
        #1;
        hit_access(32'h40, 32'hCCCC_0040);
        chk("t4_hits", {16'd0, hit_count}, 32'd9);

        // Flush coincident with fill completion discards the install.
        pulse_flush();
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        cyc();
        iwait = 1'b0;
        iload = 32'hEEEE_0040;
        flush = 1'b1;
        cyc();
        flush   = 1'b0;
        iwait   = 1'b1;
        imemREN = 1'b0;
        #1;
        chk("t5_iren", {31'd0, iREN}, 32'd0);
        fetch_fill(32'h40, 32'hFFFF_0040, 0);
        chk("t5_misses", {16'd0, miss_count}, 32'd9);
        chk("t5_hits", {16'd0, hit_count}, 32'd10);

        // Reset during an outstanding fetch.
        imemREN  = 1'b1;
        imemaddr = 32'h80;
        cyc();
        chk("t6_iren_pre", {31'd0, iREN}, 32'd1);
        RST = 1'b1;
        cyc();
        RST     = 1'b0;
        imemREN = 1'b0;
        #1;
        chk("t6_iren", {31'd0, iREN}, 32'd0);
        chk("t6_iaddr", iaddr, 32'd0);
        chk("t6_hits", {16'd0, hit_count}, 32'd0);
        chk("t6_misses", {16'd0, miss_count}, 32'd0);
        fetch_fill(32'h40, 32'h1234_5678, 0);
        chk("t6_misses2", {16'd0, miss_count}, 32'd1);
        chk("t6_hits2", {16'd0, hit_count}, 32'd1);

        cyc();
        cyc();
        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
